// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch next-PC generator.
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] instr;
    logic        data_valid;
    logic        kill;
  } fetch_entry_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;
endpackage

// File: rtl/fetch_btb.sv
// fetch_btb: direct-mapped BTB with a combinational lookup and a registered update port.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic [31:0] target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target
);
  localparam int IW = $clog2(BTB_ENTRIES);
  btb_entry_t mem [BTB_ENTRIES];
  logic [IW-1:0] lk_idx;
  logic [IW-1:0] up_idx;
  assign lk_idx = lookup_pc[IW+1:2];
  assign up_idx = upd_pc[IW+1:2];
  // Tags keep the full upper PC zero-extended so the struct stays parameter-free.
  assign hit    = mem[lk_idx].valid && (mem[lk_idx].tag == (lookup_pc >> (IW + 2)));
  assign target = mem[lk_idx].target;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) mem[i] <= '0;
    end else if (upd_valid) begin
      mem[up_idx] <= '{valid: 1'b1, tag: upd_pc >> (IW + 2), target: upd_target};
    end
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC selection, in-order imem requests and a pending-fetch FIFO feeding decode.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          BTB_ENTRIES     = 16,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_redirect_valid,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_btb_update_valid,
  input  logic [31:0] ex_btb_update_pc,
  input  logic [31:0] ex_btb_update_target,
  output logic [31:0] bht_addr,
  input  logic        bht_taken,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target
);
  localparam int LW = $clog2(MAX_OUTSTANDING);
  fetch_entry_t q [MAX_OUTSTANDING];
  fetch_entry_t h;
  logic [31:0] pc_q;
  logic [31:0] btb_target;
  logic [31:0] pred_target;
  logic [LW-1:0] head;
  logic [LW-1:0] tail;
  logic [LW-1:0] rptr;
  logic [LW:0] count;
  logic [LW:0] pending;
  logic btb_hit;
  logic pred_taken;
  logic full;
  logic req_hs;
  logic resp_ok;
  logic head_occ;
  logic drop;
  logic deq;

  fetch_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .lookup_pc (pc_q),
    .hit       (btb_hit),
    .target    (btb_target),
    .upd_valid (ex_btb_update_valid),
    .upd_pc    (ex_btb_update_pc),
    .upd_target(ex_btb_update_target)
  );

  assign pred_taken     = btb_hit && bht_taken;
  assign pred_target    = pred_taken ? btb_target : '0;
  assign full           = count == (LW + 1)'(MAX_OUTSTANDING);
  assign imem_req_valid = rst_n && !full && !ex_redirect_valid;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc_q;
  assign bht_addr       = pc_q;
  assign resp_ok        = imem_resp_valid && (pending != '0);
  assign h              = q[head];
  assign head_occ       = count != '0;
  assign if_valid       = head_occ && h.data_valid && !h.kill;
  assign drop           = head_occ && h.data_valid && h.kill;
  assign deq            = (if_valid && if_ready) || drop;
  assign if_pc          = h.pc;
  assign if_instr       = h.instr;
  assign if_pred_taken  = h.pred_taken;
  assign if_pred_target = h.pred_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      head    <= '0;
      tail    <= '0;
      rptr    <= '0;
      count   <= '0;
      pending <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) q[i] <= '0;
    end else begin
      pc_q <= ex_redirect_valid ? ex_redirect_pc :
              req_hs ? (pred_taken ? btb_target : pc_q + 32'(INSTR_BYTES)) : pc_q;
      // Killing free slots too is harmless: a redirect never enqueues, and enqueue rewrites kill.
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (req_hs && tail == LW'(i))
          q[i] <= '{pc: pc_q, pred_taken: pred_taken, pred_target: pred_target,
                    instr: '0, data_valid: 1'b0, kill: 1'b0};
        if (resp_ok && rptr == LW'(i)) begin
          q[i].instr      <= imem_resp_data;
          q[i].data_valid <= 1'b1;
        end
        if (ex_redirect_valid) q[i].kill <= 1'b1;
      end
      head    <= head + LW'(deq);
      tail    <= tail + LW'(req_hs);
      rptr    <= rptr + LW'(resp_ok);
      count   <= count + (LW + 1)'(req_hs) - (LW + 1)'(deq);
      pending <= pending + (LW + 1)'(req_hs) - (LW + 1)'(resp_ok);
    end
  end

  resp_has_pending: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> pending != '0)
    else $error("imem response with no outstanding fetch");
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_fetch_pc_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_redirect_valid = 1'b0;
  logic [31:0] ex_redirect_pc = '0;
  logic        ex_btb_update_valid = 1'b0;
  logic [31:0] ex_btb_update_pc = '0;
  logic [31:0] ex_btb_update_target = '0;
  logic [31:0] bht_addr;
  logic        bht_taken = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;

  fetch_pc_gen dut (
    .clk(clk), .rst_n(rst_n),
    .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
    .ex_btb_update_valid(ex_btb_update_valid), .ex_btb_update_pc(ex_btb_update_pc),
    .ex_btb_update_target(ex_btb_update_target),
    .bht_addr(bht_addr), .bht_taken(bht_taken),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] instr;
    logic        pt;
    logic        dv;
    logic        kill;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        btb_v[16];
  logic [31:0] btb_tag[16];
  logic [31:0] btb_tgt[16];
  logic [31:0] mem_q[$];
  logic [31:0] req_log[$];
  logic [31:0] dec_log[$];
  logic [31:0] dec_tgt[$];
  logic        dec_pt[$];
  logic        m_hs, m_deq, m_pt;
  logic [31:0] m_ptgt;
  logic        s_hs, s_req_valid, s_if_valid;
  logic [31:0] s_req_addr;
  int passed = 0;
  int total = 0;

  logic        redir = 0, upd = 0, bht = 0, rdy = 0, irdy = 0, resp_en = 0;
  logic [31:0] redir_pc = 0, upd_pc = 0, upd_tgt = 0;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_q(string name, logic [31:0] q[$], int i, logic [31:0] exp);
    if (i < q.size()) chk(name, q[i], exp);
    else chk(name, 32'hxxxx_xxxx, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    mq.delete();
    mem_q.delete();
    for (int i = 0; i < 16; i++) btb_v[i] = 1'b0;
  endtask

  task automatic step();
    int ix;
    logic hit, exp_rv, exp_iv, found;
    ent_t e;
    @(negedge clk);
    ex_redirect_valid    = redir;
    ex_redirect_pc       = redir_pc;
    ex_btb_update_valid  = upd;
    ex_btb_update_pc     = upd_pc;
    ex_btb_update_target = upd_tgt;
    bht_taken            = bht;
    imem_req_ready       = rdy;
    if_ready             = irdy;
    imem_resp_valid      = rst_n && resp_en && mem_q.size() > 0;
    imem_resp_data       = imem_resp_valid ? word_at(mem_q[0]) : 32'h0;
    #1;
    if (!rst_n) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      model_reset();
    end else begin
      ix     = int'(m_pc[5:2]);
      hit    = btb_v[ix] && btb_tag[ix] == (m_pc >> 6);
      m_pt   = hit && bht;
      m_ptgt = m_pt ? btb_tgt[ix] : 32'h0;
      exp_rv = mq.size() < 2 && !redir;
      exp_iv = mq.size() > 0 && mq[0].dv && !mq[0].kill;
      m_hs   = exp_rv && rdy;
      m_deq  = mq.size() > 0 && mq[0].dv && (mq[0].kill || irdy);
      chk("req_valid", imem_req_valid, exp_rv);
      chk("req_addr", imem_req_addr, m_pc);
      chk("bht_addr", bht_addr, m_pc);
      chk("if_valid", if_valid, exp_iv);
      if (exp_iv) begin
        chk("if_pc", if_pc, mq[0].pc);
        chk("if_instr", if_instr, mq[0].instr);
        chk("if_pred_taken", if_pred_taken, mq[0].pt);
        chk("if_pred_target", if_pred_target, mq[0].tgt);
      end
    end
    s_hs        = imem_req_valid && imem_req_ready;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    if (s_hs) req_log.push_back(imem_req_addr);
    if (if_valid && if_ready) begin
      dec_log.push_back(if_pc);
      dec_pt.push_back(if_pred_taken);
      dec_tgt.push_back(if_pred_target);
    end
    @(posedge clk);
    if (rst_n) begin
      if (imem_resp_valid) begin
        void'(mem_q.pop_front());
        found = 1'b0;
        for (int i = 0; i < mq.size(); i++)
          if (!found && !mq[i].dv) begin
            mq[i].instr = imem_resp_data;
            mq[i].dv    = 1'b1;
            found       = 1'b1;
          end
      end
      if (s_hs) mem_q.push_back(s_req_addr);
      if (redir) for (int i = 0; i < mq.size(); i++) mq[i].kill = 1'b1;
      if (m_deq) void'(mq.pop_front());
      if (m_hs) begin
        e.pc = m_pc; e.tgt = m_ptgt; e.instr = 32'h0; e.pt = m_pt; e.dv = 1'b0; e.kill = 1'b0;
        mq.push_back(e);
      end
      m_pc = redir ? redir_pc : m_hs ? (m_pt ? m_ptgt : m_pc + 32'd4) : m_pc;
      if (upd) begin
        btb_v[upd_pc[5:2]]   = 1'b1;
        btb_tag[upd_pc[5:2]] = upd_pc >> 6;
        btb_tgt[upd_pc[5:2]] = upd_tgt;
      end
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    redir = 0; upd = 0; bht = 0; rdy = 0; irdy = 0; resp_en = 0;
    repeat (2) step();
    req_log.delete(); dec_log.delete(); dec_pt.delete(); dec_tgt.delete();
    #2 rst_n = 1'b1;
  endtask

  task automatic go(int n);
    repeat (n) step();
  endtask

  initial begin
    int n, n20;
    model_reset();
    // in-order fetch with an empty BTB
    do_reset();
    chk("reset_pc", imem_req_addr, 32'h0);
    rdy = 1; irdy = 1; resp_en = 1;
    go(10);
    chk_q("seq_req0", req_log, 0, 32'h0);
    chk_q("seq_req1", req_log, 1, 32'h4);
    chk_q("seq_req2", req_log, 2, 32'h8);
    chk_q("seq_dec0", dec_log, 0, 32'h0);
    chk_q("seq_dec1", dec_log, 1, 32'h4);
    chk_q("seq_dec2", dec_log, 2, 32'h8);
    chk("seq_pt", (dec_pt.size() > 2) ? (dec_pt[0] | dec_pt[1] | dec_pt[2]) : 1'bx, 0);
    // BTB hit plus BHT taken steers fetch
    do_reset();
    rdy = 1; irdy = 1; resp_en = 1; bht = 1; upd = 1; upd_pc = 32'h8; upd_tgt = 32'h40;
    step();
    upd = 0;
    go(9);
    chk_q("btb_req3", req_log, 3, 32'h40);
    chk_q("btb_dec_pc", dec_log, 2, 32'h8);
    chk("btb_dec_pt", (dec_pt.size() > 2) ? dec_pt[2] : 1'bx, 1);
    chk_q("btb_dec_tgt", dec_tgt, 2, 32'h40);
    bht = 0; redir = 1; redir_pc = 32'h8;
    step();
    redir = 0;
    n = req_log.size();
    go(6);
    chk_q("nt_req_a", req_log, n, 32'h8);
    chk_q("nt_req_b", req_log, n + 1, 32'hC);
    // redirect with two fetches in flight
    do_reset();
    rdy = 1; irdy = 1; redir = 1; redir_pc = 32'h10;
    step();
    redir = 0;
    go(3);
    chk_q("fl_req0", req_log, 0, 32'h10);
    chk_q("fl_req1", req_log, 1, 32'h14);
    dec_log.delete();
    redir = 1; redir_pc = 32'h100; resp_en = 1;
    step();
    redir = 0;
    step();
    chk("redir_addr_t1", s_req_addr, 32'h100);
    go(10);
    chk_q("fl_dec0", dec_log, 0, 32'h100);
    chk_q("fl_dec1", dec_log, 1, 32'h104);
    // decode backpressure stalls fetch without loss
    do_reset();
    rdy = 1; resp_en = 1;
    go(6);
    chk("bp_reqs", req_log.size(), 2);
    chk("bp_req_valid", s_req_valid, 0);
    irdy = 1;
    step();
    irdy = 0;
    go(3);
    chk("bp_dec_one", dec_log.size(), 1);
    chk("bp_req_three", req_log.size(), 3);
    irdy = 1;
    go(6);
    chk_q("bp_dec0", dec_log, 0, 32'h0);
    chk_q("bp_dec1", dec_log, 1, 32'h4);
    chk_q("bp_dec2", dec_log, 2, 32'h8);
    // redirect coinciding with the response for 0x20
    do_reset();
    rdy = 1; irdy = 1; redir = 1; redir_pc = 32'h20;
    step();
    redir = 0;
    step();
    redir = 1; redir_pc = 32'h80; resp_en = 1;
    step();
    redir = 0;
    go(10);
    n20 = 0;
    foreach (dec_log[i]) if (dec_log[i] == 32'h20) n20++;
    chk("kill_0x20", n20, 0);
    chk_q("kill_dec0", dec_log, 0, 32'h80);
    // 32-bit wrap of sequential PC
    do_reset();
    rdy = 1; irdy = 1; resp_en = 1; redir = 1; redir_pc = 32'hFFFF_FFF8;
    step();
    redir = 0;
    go(8);
    chk_q("wrap0", req_log, 0, 32'hFFFF_FFF8);
    chk_q("wrap1", req_log, 1, 32'hFFFF_FFFC);
    chk_q("wrap2", req_log, 2, 32'h0);
    // asynchronous reset with a full FIFO clears BTB and queue
    do_reset();
    rdy = 1; resp_en = 1; bht = 1; upd = 1; upd_pc = 32'h0; upd_tgt = 32'h60;
    step();
    upd = 0;
    go(5);
    chk("full_if_valid", s_if_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_if_valid", if_valid, 0);
    chk("async_req_valid", imem_req_valid, 0);
    model_reset();
    do_reset();
    rdy = 1; irdy = 1; resp_en = 1; bht = 1;
    go(6);
    chk_q("post_rst_req0", req_log, 0, 32'h0);
    chk_q("post_rst_req1", req_log, 1, 32'h4);
    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        #3 rst_n = 1'b0;
        #1;
        chk("rand_async_if_valid", if_valid, 0);
        chk("rand_async_req_valid", imem_req_valid, 0);
        model_reset();
        do_reset();
      end
      redir    = $urandom_range(0, 11) == 0;
      redir_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 63) * 4);
      upd      = $urandom_range(0, 5) == 0;
      upd_pc   = 32'($urandom_range(0, 63) * 4);
      upd_tgt  = 32'($urandom_range(0, 63) * 4);
      bht      = 1'($urandom_range(0, 1));
      rdy      = $urandom_range(0, 3) != 0;
      irdy     = $urandom_range(0, 4) > 1;
      resp_en  = $urandom_range(0, 4) != 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
